// File: rtl/parity_frame_checker.sv
// Serial 4-bit frame checker: collects a,b,c,p and reports {a,b,c} with a parity verdict.
// Optional saturating parity-error counter enabled by macro PARITY_ERR_CNT_EN.
module parity_frame_checker #(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       sof,
    output logic [2:0] abc,
    output logic       frame_valid,
    output logic       parity_err,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        GOT_B = 2'd2,
        GOT_C = 2'd3
    } state_t;

    state_t     state_q;
    logic       a_q, b_q, c_q;
    logic [2:0] abc_q;
    logic       frame_valid_q;
    logic       parity_err_q;

    // Frame assembly; a sof bit always restarts the frame, even mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= 1'b0;
            b_q           <= 1'b0;
            c_q           <= 1'b0;
            abc_q         <= 3'b000;
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            if (bit_valid) begin
                if (sof) begin
                    a_q     <= bit_in;
                    state_q <= GOT_A;
                end else begin
                    case (state_q)
                        IDLE: ;
                        GOT_A: begin
                            b_q     <= bit_in;
                            state_q <= GOT_B;
                        end
                        GOT_B: begin
                            c_q     <= bit_in;
                            state_q <= GOT_C;
                        end
                        GOT_C: begin
                            abc_q         <= {a_q, b_q, c_q};
                            parity_err_q  <= a_q ^ b_q ^ c_q ^ bit_in ^ ODD_PARITY;
                            frame_valid_q <= 1'b1;
                            state_q       <= IDLE;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign abc         = abc_q;
    assign frame_valid = frame_valid_q;
    assign parity_err  = parity_err_q;
    assign busy        = (state_q != IDLE);

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    // Counts reported bad frames, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (frame_valid_q && parity_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized bench for parity_frame_checker against a bit-list frame model.
// Expects err_cnt to count only when PARITY_ERR_CNT_EN is defined.
module tb_parity_frame_checker;

    localparam bit ODD = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       sof;
    logic [2:0] abc;
    logic       frame_valid;
    logic       parity_err;
    logic       busy;
    logic [7:0] err_cnt;

    parity_frame_checker #(.ODD_PARITY(ODD)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .sof         (sof),
        .abc         (abc),
        .frame_valid (frame_valid),
        .parity_err  (parity_err),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: the list of bits collected so far for the frame in progress.
    bit       frame_bits[$];
    bit       exp_fv;
    bit [2:0] exp_abc;
    bit       exp_perr;
    int       exp_cnt;
    int       pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_visible(input int c);
`ifdef PARITY_ERR_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit v, input bit b, input bit s, input bit r);
        bit_valid = v;
        bit_in    = b;
        sof       = s;
        rst       = r;
        @(posedge clk);
        if (r) begin
            frame_bits.delete();
            exp_fv = 0; exp_abc = 3'b000; exp_perr = 0; exp_cnt = 0;
        end else begin
            if (exp_fv && exp_perr && exp_cnt < 255) exp_cnt++;
            exp_fv = 0;
            if (v) begin
                if (s) begin
                    frame_bits.delete();
                    frame_bits.push_back(b);
                end else if (frame_bits.size() > 0) begin
                    frame_bits.push_back(b);
                end
                if (frame_bits.size() == 4) begin
                    exp_abc  = {frame_bits[0], frame_bits[1], frame_bits[2]};
                    exp_perr = frame_bits[0] ^ frame_bits[1] ^ frame_bits[2] ^ frame_bits[3] ^ ODD;
                    exp_fv   = 1;
                    frame_bits.delete();
                end
            end
        end
        #1;
        if (frame_valid === 1'b1) pulses++;
        check("frame_valid", 32'(frame_valid), 32'(exp_fv));
        check("abc",         32'(abc),         32'(exp_abc));
        check("parity_err",  32'(parity_err),  32'(exp_perr));
        check("busy",        32'(busy),        32'(frame_bits.size() > 0));
        check("err_cnt",     32'(err_cnt),     32'(cnt_visible(exp_cnt)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    endtask

    // Send one bit, optionally preceded by a random invalid gap.
    task automatic send(input bit b, input bit s, input bit gaps);
        if (gaps) idle($urandom_range(0, 3));
        step(1, b, s, 0);
    endtask

    task automatic send_frame(input bit [2:0] d, input bit p, input bit gaps);
        send(d[2], 1, gaps);
        send(d[1], 0, gaps);
        send(d[0], 0, gaps);
        send(p, 0, gaps);
    endtask

    initial begin
        bit_valid = 0; bit_in = 0; sof = 0; rst = 1;
        exp_fv = 0; exp_abc = 0; exp_perr = 0; exp_cnt = 0; pulses = 0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Basic frame 1,0,1,0 then one idle cycle to see the pulse drop.
        send_frame(3'b101, 1'b0, 0);
        check("basic_fv",   32'(frame_valid), 32'd1);
        check("basic_abc",  32'(abc),         32'd5);
        check("basic_perr", 32'(parity_err),  32'd0);
        idle(1);
        check("basic_pulse_width", 32'(frame_valid), 32'd0);

        // Bad parity frame 1,1,1,0.
        send_frame(3'b111, 1'b0, 0);
        check("bad_perr", 32'(parity_err), 32'd1);
        idle(2);
        check("bad_cnt", 32'(err_cnt), 32'(cnt_visible(1)));

        // All abc values with correct parity, back-to-back then with gaps.
        for (int g = 0; g < 2; g++) begin
            pulses = 0;
            for (int d = 0; d < 8; d++) send_frame(3'(d), ^3'(d), g[0]);
            idle(2);
            check("sweep_pulses", 32'(pulses), 32'd8);
        end

        // Restart mid-frame: 1(sof),1 then 0(sof),0,1,1.
        pulses = 0;
        send(1, 1, 0); send(1, 0, 0);
        send_frame(3'b001, 1'b1, 0);
        idle(2);
        check("restart_pulses", 32'(pulses), 32'd1);
        check("restart_abc",    32'(abc),    32'd1);

        // Reset in GOT_B, with a competing sof bit, then stray non-sof bits.
        pulses = 0;
        send(1, 1, 0); send(0, 0, 0);
        step(1, 1, 1, 1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_abc",  32'(abc),  32'd0);
        send(1, 0, 0); send(0, 0, 0);
        idle(2);
        check("rst_pulses", 32'(pulses), 32'd0);
        check("rst_busy2",  32'(busy),   32'd0);

        // Counter saturation with 300 erroneous frames.
        for (int f = 0; f < 300; f++) begin
            bit [2:0] d;
            d = 3'($urandom_range(0, 7));
            send_frame(d, ~(^d) ^ ODD, 0);
        end
        idle(3);
        check("sat_cnt", 32'(err_cnt), 32'(cnt_visible(255)));

        // Random traffic including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
